// File: rtl/reg_wb_sched_if.sv
// Bundle of issue, writeback-request and register-file write signals for reg_wb_sched.
// slave is the scheduler's view; master is the decoder/execution side.
interface reg_wb_sched_if #(
    parameter int NREG = 16,
    parameter int AW   = 4,
    parameter int DW   = 8
);
    logic            issue_valid;
    logic            issue_has_dst;
    logic [AW-1:0]   issue_src0;
    logic [AW-1:0]   issue_src1;
    logic [AW-1:0]   issue_dst;
    logic            issue_ready;

    logic            alu_req;
    logic [AW-1:0]   alu_dst;
    logic [DW-1:0]   alu_data;
    logic            alu_gnt;

    logic            mem_req;
    logic [AW-1:0]   mem_dst;
    logic [DW-1:0]   mem_data;
    logic            mem_gnt;

    logic            rf_we;
    logic [AW-1:0]   rf_dst;
    logic [DW-1:0]   rf_data;

    logic [NREG-1:0] busy;
    logic [AW:0]     pending;
    logic            wb_err;

    modport slave (
        input  issue_valid, issue_has_dst, issue_src0, issue_src1, issue_dst,
        output issue_ready,
        input  alu_req, alu_dst, alu_data,
        output alu_gnt,
        input  mem_req, mem_dst, mem_data,
        output mem_gnt,
        output rf_we, rf_dst, rf_data,
        output busy, pending, wb_err
    );

    modport master (
        output issue_valid, issue_has_dst, issue_src0, issue_src1, issue_dst,
        input  issue_ready,
        output alu_req, alu_dst, alu_data,
        input  alu_gnt,
        output mem_req, mem_dst, mem_data,
        input  mem_gnt,
        input  rf_we, rf_dst, rf_data,
        input  busy, pending, wb_err
    );
endinterface

// File: rtl/reg_wb_sched.sv
// Register scoreboard with RAW/WAW issue stall, ALU/MEM writeback arbitration
// and a single registered write stage feeding the register file.
module reg_wb_sched #(
    parameter int NREG       = 16,
    parameter int AW         = 4,
    parameter int DW         = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_wb_sched_if.slave     bus
);

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [AW:0]     pending_reg;
    logic [AW:0]     pending_next;

    logic            rf_we_reg;
    logic [AW-1:0]   rf_dst_reg;
    logic [DW-1:0]   rf_data_reg;
    logic            wb_err_reg;
    logic            wb_err_next;

    // 1 = MEM wins the next contested cycle, 0 = ALU wins.
    logic            prefer_mem_reg;
    logic            prefer_mem_next;
    logic            prefer_mem;

    logic            src0_busy;
    logic            src1_busy;
    logic            dst_busy;
    logic            issue_ready_w;
    logic            issue_fire;

    logic            contested;
    logic            alu_gnt_w;
    logic            mem_gnt_w;
    logic            grant_w;
    logic [AW-1:0]   wb_dst_w;
    logic [DW-1:0]   wb_data_w;
    logic            wb_dst_idle;

    // Issue hazard check: both sources always, destination only when written.
    assign src0_busy     = busy_reg[bus.issue_src0];
    assign src1_busy     = busy_reg[bus.issue_src1];
    assign dst_busy      = busy_reg[bus.issue_dst];
    assign issue_ready_w = bus.issue_valid & ~src0_busy & ~src1_busy
                         & ~(bus.issue_has_dst & dst_busy);
    assign issue_fire    = issue_ready_w;

    // Fixed priority is round-robin with the pointer pinned to MEM.
    assign prefer_mem = (FIXED_PRIO != 0) ? 1'b1 : prefer_mem_reg;
    assign contested  = bus.alu_req & bus.mem_req;
    assign alu_gnt_w  = bus.alu_req & (~bus.mem_req | ~prefer_mem);
    assign mem_gnt_w  = bus.mem_req & (~bus.alu_req |  prefer_mem);
    assign grant_w    = alu_gnt_w | mem_gnt_w;

    assign prefer_mem_next = contested ? alu_gnt_w : prefer_mem_reg;

    assign wb_dst_w    = alu_gnt_w ? bus.alu_dst  : bus.mem_dst;
    assign wb_data_w   = alu_gnt_w ? bus.alu_data : bus.mem_data;
    assign wb_dst_idle = ~busy_reg[wb_dst_w];
    assign wb_err_next = wb_err_reg | (grant_w & wb_dst_idle);

    // Busy clears at the end of the cycle the register file is written, so
    // dependents stall until the new value is architecturally visible.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            assign set_vec[gi]   = issue_fire & bus.issue_has_dst
                                 & (bus.issue_dst == AW'(gi));
            assign clr_vec[gi]   = rf_we_reg & (rf_dst_reg == AW'(gi));
            assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    always_comb begin
        pending_next = '0;
        for (int i = 0; i < NREG; i++) begin
            pending_next = pending_next + (AW+1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_reg       <= '0;
            pending_reg    <= '0;
            rf_we_reg      <= 1'b0;
            rf_dst_reg     <= '0;
            rf_data_reg    <= '0;
            wb_err_reg     <= 1'b0;
            prefer_mem_reg <= 1'b0;
        end else begin
            busy_reg       <= busy_next;
            pending_reg    <= pending_next;
            rf_we_reg      <= grant_w;
            wb_err_reg     <= wb_err_next;
            prefer_mem_reg <= prefer_mem_next;
            if (grant_w) begin
                rf_dst_reg  <= wb_dst_w;
                rf_data_reg <= wb_data_w;
            end
        end
    end

    assign bus.issue_ready = issue_ready_w;
    assign bus.alu_gnt     = alu_gnt_w;
    assign bus.mem_gnt     = mem_gnt_w;
    assign bus.rf_we       = rf_we_reg;
    assign bus.rf_dst      = rf_dst_reg;
    assign bus.rf_data     = rf_data_reg;
    assign bus.busy        = busy_reg;
    assign bus.pending     = pending_reg;
    assign bus.wb_err      = wb_err_reg;

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed bench: round-robin (u0) and fixed-priority (u1) schedulers; expected
// register-file writes are queued at grant time and checked by per-DUT monitors.
module tb_reg_wb_sched;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    logic [11:0] q0[$];
    logic [11:0] q1[$];

    always #5 clk = ~clk;

    reg_wb_sched_if #(.NREG(16), .AW(4), .DW(8)) b0 ();
    reg_wb_sched_if #(.NREG(16), .AW(4), .DW(8)) b1 ();

    reg_wb_sched #(.NREG(16), .AW(4), .DW(8), .FIXED_PRIO(0)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    reg_wb_sched #(.NREG(16), .AW(4), .DW(8), .FIXED_PRIO(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        b0.issue_valid = 0; b0.issue_has_dst = 0; b0.issue_src0 = 0; b0.issue_src1 = 0; b0.issue_dst = 0;
        b0.alu_req = 0; b0.alu_dst = 0; b0.alu_data = 0;
        b0.mem_req = 0; b0.mem_dst = 0; b0.mem_data = 0;
        b1.issue_valid = 0; b1.issue_has_dst = 0; b1.issue_src0 = 0; b1.issue_src1 = 0; b1.issue_dst = 0;
        b1.alu_req = 0; b1.alu_dst = 0; b1.alu_data = 0;
        b1.mem_req = 0; b1.mem_dst = 0; b1.mem_data = 0;
    endtask

    task automatic issue0(input logic has_dst, input logic [3:0] s0, input logic [3:0] s1,
                          input logic [3:0] d);
        b0.issue_valid = 1; b0.issue_has_dst = has_dst;
        b0.issue_src0 = s0; b0.issue_src1 = s1; b0.issue_dst = d;
    endtask

    // Monitors: every register-file write must match the oldest queued grant.
    always @(negedge clk) begin
        logic [11:0] exp0;
        if (b0.rf_we === 1'b1) begin
            n_vec++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL wb0_unexpected: got r%0d=0x%02h required no write", b0.rf_dst, b0.rf_data);
            end else begin
                exp0 = q0.pop_front();
                $display("wb0 r%0d <= 0x%02h", b0.rf_dst, b0.rf_data);
                if ({b0.rf_dst, b0.rf_data} !== exp0) begin
                    n_err++;
                    $display("FAIL wb0: got r%0d=0x%02h required r%0d=0x%02h",
                             b0.rf_dst, b0.rf_data, exp0[11:8], exp0[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] exp1;
        if (b1.rf_we === 1'b1) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL wb1_unexpected: got r%0d=0x%02h required no write", b1.rf_dst, b1.rf_data);
            end else begin
                exp1 = q1.pop_front();
                $display("wb1 r%0d <= 0x%02h", b1.rf_dst, b1.rf_data);
                if ({b1.rf_dst, b1.rf_data} !== exp1) begin
                    n_err++;
                    $display("FAIL wb1: got r%0d=0x%02h required r%0d=0x%02h",
                             b1.rf_dst, b1.rf_data, exp1[11:8], exp1[7:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        idle_all();
        repeat (3) cyc();
        chk("rst_busy", 32'(b0.busy), 32'h0);
        chk("rst_pending", 32'(b0.pending), 32'h0);
        chk("rst_rf_we", 32'(b0.rf_we), 32'h0);
        chk("rst_rf_dst", 32'(b0.rf_dst), 32'h0);
        chk("rst_rf_data", 32'(b0.rf_data), 32'h0);
        chk("rst_wb_err", 32'(b0.wb_err), 32'h0);
        rst_n = 1;
        cyc();

        // Issue r3 <- r0,r1
        issue0(1, 4'd0, 4'd1, 4'd3);
        @(negedge clk);
        chk("issue_r3_ready", 32'(b0.issue_ready), 32'h1);
        cyc();
        b0.issue_valid = 0;
        chk("issue_r3_busy", 32'(b0.busy), 32'h0008);
        chk("issue_r3_pending", 32'(b0.pending), 32'h1);

        // RAW on r3, ALU writes r3 = A5
        issue0(0, 4'd3, 4'd0, 4'd0);
        b0.alu_req = 1; b0.alu_dst = 4'd3; b0.alu_data = 8'hA5;
        @(negedge clk);
        chk("raw_stall", 32'(b0.issue_ready), 32'h0);
        chk("alu_gnt_single", 32'(b0.alu_gnt), 32'h1);
        chk("mem_gnt_idle", 32'(b0.mem_gnt), 32'h0);
        q0.push_back({4'd3, 8'hA5});
        cyc();
        b0.alu_req = 0;
        chk("raw_wb_we", 32'(b0.rf_we), 32'h1);
        chk("raw_busy_held", 32'(b0.busy), 32'h0008);
        @(negedge clk);
        chk("raw_stall_wb_cycle", 32'(b0.issue_ready), 32'h0);
        cyc();
        chk("raw_busy_clear", 32'(b0.busy), 32'h0);
        chk("raw_pending_clear", 32'(b0.pending), 32'h0);
        @(negedge clk);
        chk("raw_release", 32'(b0.issue_ready), 32'h1);
        cyc();
        b0.issue_valid = 0;

        // WAW on r5
        issue0(1, 4'd0, 4'd0, 4'd5);
        cyc();
        chk("waw_busy_set", 32'(b0.busy), 32'h0020);
        b0.mem_req = 1; b0.mem_dst = 4'd5; b0.mem_data = 8'h5C;
        @(negedge clk);
        chk("waw_stall", 32'(b0.issue_ready), 32'h0);
        chk("waw_mem_gnt", 32'(b0.mem_gnt), 32'h1);
        chk("waw_alu_gnt", 32'(b0.alu_gnt), 32'h0);
        q0.push_back({4'd5, 8'h5C});
        cyc();
        b0.mem_req = 0;
        @(negedge clk);
        chk("waw_stall_wb_cycle", 32'(b0.issue_ready), 32'h0);
        cyc();
        @(negedge clk);
        chk("waw_release", 32'(b0.issue_ready), 32'h1);
        cyc();
        chk("waw_busy_reset", 32'(b0.busy), 32'h0020);

        // Make r1..r4 busy for the arbitration test
        for (int r = 1; r <= 4; r++) begin
            issue0(1, 4'd0, 4'd0, 4'(r));
            @(negedge clk);
            chk("issue_r1_4_ready", 32'(b0.issue_ready), 32'h1);
            cyc();
        end
        b0.issue_valid = 0;
        chk("multi_busy", 32'(b0.busy), 32'h003E);
        chk("multi_pending", 32'(b0.pending), 32'h5);

        // Round-robin: ALU r1/r3/r5, MEM r2/r4, both requesting for 4 cycles
        b0.alu_req = 1; b0.alu_dst = 4'd1; b0.alu_data = 8'h11;
        b0.mem_req = 1; b0.mem_dst = 4'd2; b0.mem_data = 8'h22;
        @(negedge clk);
        chk("rr1_alu", 32'({b0.alu_gnt, b0.mem_gnt}), 32'h2);
        q0.push_back({4'd1, 8'h11});
        cyc();
        b0.alu_dst = 4'd3; b0.alu_data = 8'h33;
        @(negedge clk);
        chk("rr2_mem", 32'({b0.alu_gnt, b0.mem_gnt}), 32'h1);
        q0.push_back({4'd2, 8'h22});
        cyc();
        chk("rr2_we", 32'(b0.rf_we), 32'h1);
        b0.mem_dst = 4'd4; b0.mem_data = 8'h44;
        @(negedge clk);
        chk("rr3_alu", 32'({b0.alu_gnt, b0.mem_gnt}), 32'h2);
        q0.push_back({4'd3, 8'h33});
        cyc();
        chk("rr3_we", 32'(b0.rf_we), 32'h1);
        b0.alu_dst = 4'd5; b0.alu_data = 8'h55;
        @(negedge clk);
        chk("rr4_mem", 32'({b0.alu_gnt, b0.mem_gnt}), 32'h1);
        q0.push_back({4'd4, 8'h44});
        cyc();
        chk("rr4_we", 32'(b0.rf_we), 32'h1);
        b0.mem_req = 0;
        @(negedge clk);
        chk("rr5_alu_alone", 32'({b0.alu_gnt, b0.mem_gnt}), 32'h2);
        q0.push_back({4'd5, 8'h55});
        cyc();
        chk("rr5_we", 32'(b0.rf_we), 32'h1);
        b0.alu_req = 0;
        cyc();
        chk("rr_idle_we", 32'(b0.rf_we), 32'h0);
        chk("rr_hold_dst", 32'(b0.rf_dst), 32'h5);
        chk("rr_hold_data", 32'(b0.rf_data), 32'h55);
        chk("rr_busy_clear", 32'(b0.busy), 32'h0);
        chk("rr_pending_clear", 32'(b0.pending), 32'h0);
        chk("rr_no_err", 32'(b0.wb_err), 32'h0);

        // Fixed priority: MEM wins while it requests
        b1.alu_req = 1; b1.alu_dst = 4'd6; b1.alu_data = 8'h66;
        b1.mem_req = 1; b1.mem_dst = 4'd8; b1.mem_data = 8'h88;
        @(negedge clk);
        chk("fp1_mem", 32'({b1.alu_gnt, b1.mem_gnt}), 32'h1);
        q1.push_back({4'd8, 8'h88});
        cyc();
        b1.mem_dst = 4'd9; b1.mem_data = 8'h99;
        @(negedge clk);
        chk("fp2_mem", 32'({b1.alu_gnt, b1.mem_gnt}), 32'h1);
        q1.push_back({4'd9, 8'h99});
        cyc();
        b1.mem_req = 0;
        @(negedge clk);
        chk("fp3_alu", 32'({b1.alu_gnt, b1.mem_gnt}), 32'h2);
        q1.push_back({4'd6, 8'h66});
        cyc();
        b1.alu_req = 0;
        chk("fp_wb_err", 32'(b1.wb_err), 32'h1);
        cyc();

        // Writeback to non-busy r7 sets sticky wb_err; reset mid-writeback
        b0.mem_req = 1; b0.mem_dst = 4'd7; b0.mem_data = 8'h77;
        @(negedge clk);
        chk("err_mem_gnt", 32'(b0.mem_gnt), 32'h1);
        q0.push_back({4'd7, 8'h77});
        cyc();
        chk("err_set", 32'(b0.wb_err), 32'h1);
        chk("err_write_proceeds", 32'({b0.rf_we, b0.rf_dst}), 32'h17);
        b0.mem_dst = 4'd9; b0.mem_data = 8'h99;
        issue0(1, 4'd0, 4'd0, 4'd10);
        @(negedge clk);
        chk("err_issue_ready", 32'(b0.issue_ready), 32'h1);
        q0.push_back({4'd9, 8'h99});
        cyc();
        b0.mem_req = 0;
        b0.issue_valid = 0;
        chk("err_sticky", 32'(b0.wb_err), 32'h1);
        chk("err_busy10", 32'(b0.busy), 32'h0400);
        chk("err_pending1", 32'(b0.pending), 32'h1);
        rst_n = 0;
        cyc();
        chk("mid_rst_we", 32'(b0.rf_we), 32'h0);
        chk("mid_rst_busy", 32'(b0.busy), 32'h0);
        chk("mid_rst_pending", 32'(b0.pending), 32'h0);
        chk("mid_rst_err", 32'(b0.wb_err), 32'h0);
        chk("mid_rst_dst", 32'(b0.rf_dst), 32'h0);
        chk("mid_rst_data", 32'(b0.rf_data), 32'h0);
        rst_n = 1;
        repeat (2) cyc();

        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
